// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Clocks per oversample tick, integer-truncated.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every DIV clks, synchronous clear
// restarts the period so the next tick lands DIV clks after the clear.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise wrap at DIV-1.
  always_comb begin
    // NOTE: assign every always_comb output first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking in clocked blocks so every flop samples pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver (8N1, or 8E1/8O1 when UART_PARITY_EN is defined).
// 2-FF synchronizer, falling-edge start detect, mid-bit sampling at 16x ticks,
// start glitch rejection and stop-bit framing check.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [TCW-1:0] TICK_HALF = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_oversample: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be >= 1");
  end
  if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
    $error("uart_rx_oversample: OVERSAMPLE must be even and >= 4");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_bits
    $error("uart_rx_oversample: DATA_BITS must be 5..8");
  end
  if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_par
    $error("uart_rx_oversample: PARITY_ODD must be 0 or 1");
  end

  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  rx_state_t            state_q, state_d;
  logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
`ifdef UART_PARITY_EN
  logic                 par_flag_q, par_flag_d;
  logic                 parity_err_q, parity_err_d;
`endif
  logic                 start_edge;
  logic                 tick_clr;
  logic                 tick;

  assign start_edge = rx_prev_q & ~rx_s_q;
  assign tick_clr   = (state_q == IDLE) && start_edge;

  uart_baud_tick #(
    .DIV (DIV < 1 ? 1 : DIV)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  // Frame FSM: next state, counters, shift register and output pulses.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_PARITY_EN
    par_flag_d   = par_flag_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d    = START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt_q == TICK_HALF) begin
            tick_cnt_d = '0;
            state_d    = rx_s_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            shreg_d    = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
`ifdef UART_PARITY_EN
              state_d   = PARITY;
`else
              state_d   = STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            par_flag_d = ((^shreg_q) ^ rx_s_q) != 1'(PARITY_ODD);
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d  = '0;
            rx_data_d   = shreg_q;
            rx_valid_d  = 1'b1;
            frame_err_d = ~rx_s_q;
`ifdef UART_PARITY_EN
            parity_err_d = par_flag_q;
`endif
            state_d     = IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Synchronizer, control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
      par_flag_q   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_PARITY_EN
      par_flag_q   <= par_flag_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Data shift register.
  // NOTE: no reset here; every bit is shifted in before the byte is ever copied out.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample at 1.536 MHz / 9600 baud / 16x (160 clk/bit).
module tb_uart_rx_oversample;

  localparam int CLK_FREQ   = 1536000;
  localparam int BAUD_RATE  = 9600;
  localparam int OVERSAMPLE = 16;
  localparam int PARITY_ODD = 0;
  localparam int BIT_CLKS   = 160;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;
  localparam int BUSY_CLKS  = FRAME_CLKS - BIT_CLKS / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Monitor state, sampled 2 time units after each rising edge.
  int         cyc = 0;
  int         valid_cnt = 0;
  logic [7:0] last_data = '0;
  logic [7:0] prev_data = '0;
  logic       last_ferr = 1'b0;
  logic       last_perr = 1'b0;
  int         last_valid_cyc = 0;
  int         prev_valid_cyc = 0;
  int         run = 0;
  int         max_run = 0;
  int         stray = 0;
  logic       busy_prev = 1'b0;
  int         busy_rise = 0;
  int         busy_fall = 0;
  int         v0;

  uart_rx_oversample #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_BITS  (8),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Record output pulses, pulse widths, stray error flags and busy edges.
  always @(posedge clk) begin
    cyc++;
    #2;
    if (rx_valid === 1'b1) begin
      valid_cnt++;
      prev_data      = last_data;
      last_data      = rx_data;
      last_ferr      = frame_err;
      last_perr      = parity_err;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
      if (frame_err === 1'b1 || parity_err === 1'b1) stray++;
    end
    if (busy === 1'b1 && !busy_prev) busy_rise = cyc;
    if (busy === 1'b0 && busy_prev)  busy_fall = cyc;
    busy_prev = (busy === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Start bit, 8 data bits LSB first, correct parity when enabled, stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
    send_bit((^d) ^ 1'(PARITY_ODD));
`endif
    send_bit(stop);
  endtask

`ifdef UART_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask
`endif

  initial begin
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data",    32'(rx_data),    32'h00);
    check("reset_rx_valid",   32'(rx_valid),   32'h0);
    check("reset_frame_err",  32'(frame_err),  32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    check("reset_busy",       32'(busy),       32'h0);
    rst = 1'b0;
    idle(20);

    // 1: plain frame 0xA5
    v0 = valid_cnt;
    send_frame(8'hA5, 1'b1);
    idle(2 * BIT_CLKS);
    check("t1_count",     32'(valid_cnt), 32'(v0 + 1));
    check("t1_data",      32'(last_data), 32'hA5);
    check("t1_frame_err", 32'(last_ferr), 32'h0);
    check("t1_parity",    32'(last_perr), 32'h0);
    check("t1_pulse_w",   32'(max_run),   32'd1);
    check("t1_busy_idle", 32'(busy),      32'h0);
    check("t1_busy_len",  32'(busy_fall - busy_rise), 32'(BUSY_CLKS));

    // 2: 40-clk glitch rejected, then 0x5A
    v0 = valid_cnt;
    rx = 1'b0;
    repeat (40) @(negedge clk);
    idle(300);
    check("t2_no_valid", 32'(valid_cnt), 32'(v0));
    check("t2_busy_len", 32'(busy_fall - busy_rise), 32'd80);
    check("t2_busy_idle", 32'(busy), 32'h0);
    send_frame(8'h5A, 1'b1);
    idle(2 * BIT_CLKS);
    check("t2_count", 32'(valid_cnt), 32'(v0 + 1));
    check("t2_data",  32'(last_data), 32'h5A);
    check("t2_frame_err", 32'(last_ferr), 32'h0);

    // 3: bad stop bit, line then stuck low
    v0 = valid_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (2000) @(negedge clk);
    check("t3_count",     32'(valid_cnt), 32'(v0 + 1));
    check("t3_data",      32'(last_data), 32'h3C);
    check("t3_frame_err", 32'(last_ferr), 32'h1);
    idle(400);
    check("t3_no_retrig", 32'(valid_cnt), 32'(v0 + 1));
    check("t3_busy_idle", 32'(busy),      32'h0);

    // 4: back-to-back 0x00 then 0xFF
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(2 * BIT_CLKS);
    check("t4_count",   32'(valid_cnt), 32'(v0 + 2));
    check("t4_data0",   32'(prev_data), 32'h00);
    check("t4_data1",   32'(last_data), 32'hFF);
    check("t4_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'(FRAME_CLKS));
    check("t4_frame_err", 32'(last_ferr), 32'h0);

    // 5: reset during data bit 4 of 0x5A, then 0x81
    v0 = valid_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_data",   32'(rx_data),    32'h00);
    check("t5_rst_valid",  32'(rx_valid),   32'h0);
    check("t5_rst_ferr",   32'(frame_err),  32'h0);
    check("t5_rst_perr",   32'(parity_err), 32'h0);
    check("t5_rst_busy",   32'(busy),       32'h0);
    rst = 1'b0;
    idle(400);
    send_frame(8'h81, 1'b1);
    idle(2 * BIT_CLKS);
    check("t5_count", 32'(valid_cnt), 32'(v0 + 1));
    check("t5_data",  32'(last_data), 32'h81);
    check("t5_frame_err", 32'(last_ferr), 32'h0);

    // 6: parity handling
`ifdef UART_PARITY_EN
    v0 = valid_cnt;
    send_frame_par(8'h07, 1'b0);
    idle(2 * BIT_CLKS);
    check("t6_bad_par_err",  32'(last_perr), 32'h1);
    check("t6_bad_par_data", 32'(last_data), 32'h07);
    send_frame_par(8'h07, 1'b1);
    idle(2 * BIT_CLKS);
    check("t6_good_par_err", 32'(last_perr), 32'h0);
    check("t6_count", 32'(valid_cnt), 32'(v0 + 2));
`else
    v0 = valid_cnt;
    send_frame(8'h07, 1'b1);
    idle(2 * BIT_CLKS);
    check("t6_no_par_err", 32'(last_perr), 32'h0);
    check("t6_data",       32'(last_data), 32'h07);
    check("t6_count",      32'(valid_cnt), 32'(v0 + 1));
`endif

    check("pulse_width_max", 32'(max_run), 32'd1);
    check("stray_err_flags", 32'(stray),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
